fifo_sync: RTL and testbench
============================

Name: fifo_sync

Overview:
Single-clock, parametrised FIFO. It is the synchronous successor to the team's dual-clock FIFO, for buffering inside one clock domain (DFCTRL command/data queues).
- Adds beyond the dual-clock FIFO: occupancy count, programmable almost-full/almost-empty, first-word-fall-through (FWFT) mode, sticky overflow/underflow error flags and a synchronous flush.
- No pointer synchronisers: every status output is exact and registered-state-derived.

Parameters:
- DSIZE, 8: data width in bits.
- ASIZE, 4: address width; depth DEPTH = 2**ASIZE.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- AFULL_THRESH, 2**ASIZE-2: walmost_full asserts when count >= this; legal 1..DEPTH.
- AEMPTY_THRESH, 2: ralmost_empty asserts when count <= this; legal 0..DEPTH-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high (Already decided).
- clr  in  1  synchronous flush.
- wdata  in  DSIZE  write data.
- winc  in  1  write request.
- wfull  out  1  FIFO full.
- walmost_full  out  1  count >= AFULL_THRESH.
- rinc  in  1  read request / pop.
- rdata  out  DSIZE  read data.
- rempty  out  1  FIFO empty.
- ralmost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  ASIZE+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Storage: DEPTH x DSIZE register array.
- Pointers: wptr and rptr are ASIZE+1-bit binary. Address = low ASIZE bits. Wrap is natural modulo 2**(ASIZE+1).
- Count: count = wptr - rptr, modulo 2**(ASIZE+1).
- Flags:
  - wfull = (count == DEPTH); rempty = (count == 0).
  - walmost_full and ralmost_empty compare count against the thresholds as above.
  - All flags are functions of registered state only; there is no combinational path from winc, rinc or clr.
- Accepted write: winc && !wfull. mem[waddr] <= wdata; wptr increments.
- Accepted read: rinc && !rempty. rptr increments.
- Rejected write (winc && wfull): no state change except overflow <= 1.
- Rejected read (rinc && rempty): no state change except underflow <= 1.
- Simultaneous winc and rinc:
  - Each is judged against the flags at that edge.
  - Full: read accepted, write rejected, overflow set, count becomes DEPTH-1.
  - Empty: write accepted, read rejected, underflow set, count becomes 1.
  - Otherwise both accepted; count is unchanged and data order is preserved.
- FWFT=0:
  - On an accepted read, rdata <= mem[raddr] at that edge, so data is valid the cycle after rinc.
  - rdata holds its value at all other times, including after the FIFO empties.
- FWFT=1:
  - rdata = mem[raddr] combinationally from registered state, i.e. the head word is visible while rempty=0.
  - rinc pops the head; the next word appears after the edge.
  - A write into an empty FIFO at edge N gives rempty=0 and valid rdata after edge N.
  - rdata is don't-care while rempty=1.
- clr:
  - Sets wptr=rptr=0 and clears overflow/underflow.
  - Takes priority over winc/rinc in the same cycle; neither is accepted and neither error flag is set.
  - Memory contents are not cleared.
  - In FWFT=0, rdata is held.
- rst:
  - Priority over clr and everything else.
  - Pointers 0, count 0, rempty=1, wfull=0, ralmost_empty=1, overflow=underflow=0, rdata=0 (FWFT=0 register).
  - walmost_full is 0 given the legal AFULL_THRESH.
- Reset mid-operation: all queued data is discarded; the first write after reset is the next word read.
- Elaboration: an illegal parameter combination triggers an elaboration error ($error in a generate check).

Test Plan:
All scenarios use DSIZE=8, ASIZE=4, AFULL=14, AEMPTY=2 unless noted.
- Fill and drain, FWFT=0:
  - Stimulus: write 0x00..0x0F in 16 cycles.
  - Response: count steps 1..16; walmost_full rises when count=14; wfull rises when count=16.
  - Then 16 reads: rdata = 0x00..0x0F, each one cycle after its rinc; rempty rises with count=0; ralmost_empty rises at count=2.
- Overflow and underflow:
  - 17th write while full: count stays 16 and overflow=1; the entry holding 0x0F is not overwritten.
  - Read while empty: underflow=1; both flags stay set until clr.
- Simultaneous access:
  - Count=5 with winc and rinc together for 20 cycles: count stays 5 and data order is preserved.
  - At full, winc+rinc: count becomes 15 and overflow=1.
  - At empty, winc+rinc: count becomes 1 and underflow=1.
- FWFT=1:
  - Write 0xA5 into an empty FIFO: next cycle rempty=0 and rdata=0xA5 with no rinc.
  - Then rinc: rempty=1 after that edge.
- Wrap-around:
  - 40 cycles of alternating write/read with count held at 3.
  - Pointers wrap past 31 to 0 with no spurious wfull or rempty and no data corruption (sequential pattern check).
- Flush and reset:
  - With count=9, assert clr together with winc: count=0, rempty=1, overflow=0, and the write is not stored.
  - Repeat with rst mid-burst: all outputs take their reset values the next cycle.

Source files
------------

// File: rtl/fifo_sync_if.sv
// rtl/fifo_sync_if.sv - handshake/status bundle between a fifo_sync and its user
interface fifo_sync_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
);
    logic             clr;
    logic [DSIZE-1:0] wdata;
    logic             winc;
    logic             wfull;
    logic             walmost_full;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             ralmost_empty;
    logic [ASIZE:0]   count;
    logic             overflow;
    logic             underflow;

    // User side: pushes, pops and flushes; observes data and status.
    modport master (
        output clr, wdata, winc, rinc,
        input  wfull, walmost_full, rdata, rempty, ralmost_empty,
               count, overflow, underflow
    );

    // FIFO side.
    modport slave (
        input  clr, wdata, winc, rinc,
        output wfull, walmost_full, rdata, rempty, ralmost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock FIFO with occupancy, thresholds, FWFT, sticky errors and flush
module fifo_sync #(
    parameter int DSIZE         = 8,
    parameter int ASIZE         = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = (2 ** ASIZE) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fifo_sync_if.slave   bus
);

    localparam int DEPTH = 1 << ASIZE;

    // Pointer-width constants so every compare and add is width-exact.
    localparam logic [ASIZE:0] DEPTH_C  = {1'b1, {ASIZE{1'b0}}};
    localparam logic [ASIZE:0] PTR_ONE  = {{ASIZE{1'b0}}, 1'b1};
    localparam logic [ASIZE:0] AFULL_C  = AFULL_THRESH[ASIZE:0];
    localparam logic [ASIZE:0] AEMPTY_C = AEMPTY_THRESH[ASIZE:0];

    // Reject parameter sets the flag logic cannot represent.
    if (DSIZE < 1) begin : g_bad_dsize
        $error("fifo_sync: DSIZE must be at least 1");
    end
    if (ASIZE < 1 || ASIZE > 16) begin : g_bad_asize
        $error("fifo_sync: ASIZE must be in 1..16");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("fifo_sync: FWFT must be 0 or 1");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("fifo_sync: AFULL_THRESH must be in 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_sync: AEMPTY_THRESH must be in 0..DEPTH-1");
    end

    // Storage and registered state. The extra pointer MSB separates full from empty.
    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [ASIZE:0]   wptr_q, wptr_d;
    logic [ASIZE:0]   rptr_q, rptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic [ASIZE-1:0] waddr_w;
    logic [ASIZE-1:0] raddr_w;
    logic [ASIZE:0]   count_w;
    logic             full_w;
    logic             empty_w;
    logic             wr_ok;
    logic             rd_ok;
    logic             wr_take;
    logic             rd_take;

    assign waddr_w = wptr_q[ASIZE-1:0];
    assign raddr_w = rptr_q[ASIZE-1:0];

    // Modulo subtraction gives exact occupancy even after both pointers wrap.
    assign count_w = wptr_q - rptr_q;
    assign full_w  = (count_w == DEPTH_C);
    assign empty_w = (count_w == '0);

    // Status straight from registered pointers: no path from winc/rinc/clr.
    assign bus.count         = count_w;
    assign bus.wfull         = full_w;
    assign bus.rempty        = empty_w;
    assign bus.walmost_full  = (count_w >= AFULL_C);
    assign bus.ralmost_empty = (count_w <= AEMPTY_C);
    assign bus.overflow      = overflow_q;
    assign bus.underflow     = underflow_q;

    // Accept decisions; each side is judged only against the flags at this edge.
    always_comb begin
        wr_ok   = bus.winc && !full_w;
        rd_ok   = bus.rinc && !empty_w;
        wr_take = wr_ok && !bus.clr;
        rd_take = rd_ok && !bus.clr;
    end

    // Next-state for pointers and sticky error flags; flush wins over traffic.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.clr) begin
            wptr_d      = '0;
            rptr_d      = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_ok) begin
                wptr_d = wptr_q + PTR_ONE;
            end else if (bus.winc) begin
                overflow_d = 1'b1;
            end
            if (rd_ok) begin
                rptr_d = rptr_q + PTR_ONE;
            end else if (bus.rinc) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Control state register; reset overrides flush and all traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Memory write port; contents are never cleared, only the pointers are.
    always_ff @(posedge clk) begin
        if (!rst && wr_take) begin
            mem_q[waddr_w] <= bus.wdata;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is presented directly; meaningless while rempty is high.
        assign bus.rdata = mem_q[raddr_w];
    end else begin : g_std
        logic [DSIZE-1:0] rdata_q;
        logic [DSIZE-1:0] rdata_d;

        // Load the head word only on an accepted pop; otherwise hold.
        always_comb begin
            rdata_d = rdata_q;
            if (rd_take) begin
                rdata_d = mem_q[raddr_w];
            end
        end

        // Registered read data, zero out of reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign bus.rdata = rdata_q;
    end

endmodule

// File: tb/tb_fifo_sync.sv
// tb/tb_fifo_sync.sv - randomized self-checking bench for fifo_sync in both read modes
module tb_fifo_sync;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       winc;
    logic       rinc;
    logic [7:0] wdata;

    int n_cmp;
    int n_bad;

    // Reference model: a plain queue plus sticky bits and the standard-mode read register.
    logic [7:0] mq[$];
    bit         m_ov;
    bit         m_un;
    logic [7:0] m_rd0;

    fifo_sync_if #(.DSIZE(8), .ASIZE(4)) if0 ();
    fifo_sync_if #(.DSIZE(8), .ASIZE(4)) if1 ();

    assign if0.clr   = clr;
    assign if0.winc  = winc;
    assign if0.rinc  = rinc;
    assign if0.wdata = wdata;
    assign if1.clr   = clr;
    assign if1.winc  = winc;
    assign if1.rinc  = rinc;
    assign if1.wdata = wdata;

    fifo_sync #(.DSIZE(8), .ASIZE(4), .FWFT(0), .AFULL_THRESH(14), .AEMPTY_THRESH(2)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    fifo_sync #(.DSIZE(8), .ASIZE(4), .FWFT(1), .AFULL_THRESH(14), .AEMPTY_THRESH(2)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge();
        logic [7:0] tmp;
        bit was_full;
        bit was_empty;
        if (rst) begin
            mq.delete();
            m_ov  = 0;
            m_un  = 0;
            m_rd0 = 8'h00;
        end else if (clr) begin
            mq.delete();
            m_ov = 0;
            m_un = 0;
        end else begin
            was_full  = (mq.size() == 16);
            was_empty = (mq.size() == 0);
            if (rinc) begin
                if (was_empty) m_un = 1;
                else begin
                    tmp   = mq.pop_front();
                    m_rd0 = tmp;
                end
            end
            if (winc) begin
                if (was_full) m_ov = 1;
                else mq.push_back(wdata);
            end
        end
    endtask

    task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
        winc  = w;
        wdata = d;
        rinc  = r;
        clr   = c;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        n_cmp++; if (if0.count !== 5'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", if0.count); end
        n_cmp++; if (if0.rempty !== 1'b1 || if1.rempty !== 1'b1) begin n_bad++; $display("FAIL reset_rempty got %b/%b exp 1", if0.rempty, if1.rempty); end
        n_cmp++; if (if0.wfull !== 1'b0 || if0.walmost_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b/%b exp 0/0", if0.wfull, if0.walmost_full); end
        n_cmp++; if (if0.ralmost_empty !== 1'b1) begin n_bad++; $display("FAIL reset_aempty got %b exp 1", if0.ralmost_empty); end
        n_cmp++; if (if0.overflow !== 1'b0 || if0.underflow !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b/%b exp 0/0", if0.overflow, if0.underflow); end
        n_cmp++; if (if0.rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata got %h exp 00", if0.rdata); end
        rst = 1'b0;
    endtask

    task automatic test_fill_drain();
        int ec;
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            step();
            ec = i + 1;
            n_cmp++; if (if0.count !== 5'(ec) || if1.count !== 5'(ec)) begin n_bad++; $display("FAIL fill_count got %0d/%0d exp %0d", if0.count, if1.count, ec); end
            n_cmp++; if (if0.walmost_full !== (ec >= 14)) begin n_bad++; $display("FAIL fill_afull at %0d got %b", ec, if0.walmost_full); end
            n_cmp++; if (if0.wfull !== (ec == 16)) begin n_bad++; $display("FAIL fill_wfull at %0d got %b", ec, if0.wfull); end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (if1.rdata !== 8'h00) begin n_bad++; $display("FAIL fill_fwft_head got %h exp 00", if1.rdata); end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            step();
            ec = 15 - i;
            n_cmp++; if (if0.rdata !== 8'(i)) begin n_bad++; $display("FAIL drain_rdata got %h exp %h", if0.rdata, 8'(i)); end
            n_cmp++; if (if0.count !== 5'(ec)) begin n_bad++; $display("FAIL drain_count got %0d exp %0d", if0.count, ec); end
            n_cmp++; if (if0.rempty !== (ec == 0)) begin n_bad++; $display("FAIL drain_rempty at %0d got %b", ec, if0.rempty); end
            n_cmp++; if (if0.ralmost_empty !== (ec <= 2)) begin n_bad++; $display("FAIL drain_aempty at %0d got %b", ec, if0.ralmost_empty); end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_overflow_underflow();
        logic [7:0] lastv;
        lastv = 8'h00;
        for (int i = 0; i < 16; i++) begin
            lastv = 8'($urandom);
            drive(1'b1, lastv, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, ~lastv, 1'b0, 1'b0);
        step();
        n_cmp++; if (if0.count !== 5'd16 || if1.count !== 5'd16) begin n_bad++; $display("FAIL ovf_count got %0d/%0d exp 16", if0.count, if1.count); end
        n_cmp++; if (if0.overflow !== 1'b1 || if1.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b/%b exp 1", if0.overflow, if1.overflow); end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            step();
            n_cmp++; if (if0.rdata !== m_rd0) begin n_bad++; $display("FAIL ovf_drain got %h exp %h", if0.rdata, m_rd0); end
        end
        n_cmp++; if (if0.rdata !== lastv) begin n_bad++; $display("FAIL ovf_last_intact got %h exp %h", if0.rdata, lastv); end
        step();
        n_cmp++; if (if0.underflow !== 1'b1 || if1.underflow !== 1'b1) begin n_bad++; $display("FAIL udf_flag got %b/%b exp 1", if0.underflow, if1.underflow); end
        n_cmp++; if (if0.count !== 5'd0 || if0.rdata !== lastv) begin n_bad++; $display("FAIL udf_hold got cnt %0d rd %h exp 0 %h", if0.count, if0.rdata, lastv); end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) step();
        n_cmp++; if (if0.overflow !== 1'b1 || if0.underflow !== 1'b1) begin n_bad++; $display("FAIL sticky got %b/%b exp 1/1", if0.overflow, if0.underflow); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        step();
        n_cmp++; if (if0.overflow !== 1'b0 || if0.underflow !== 1'b0) begin n_bad++; $display("FAIL clr_err got %b/%b exp 0/0", if0.overflow, if0.underflow); end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_simultaneous();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'($urandom), 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'($urandom), 1'b1, 1'b0);
            step();
            n_cmp++; if (if0.count !== 5'd5 || if1.count !== 5'd5) begin n_bad++; $display("FAIL simul_count got %0d/%0d exp 5", if0.count, if1.count); end
            n_cmp++; if (if0.rdata !== m_rd0 || if1.rdata !== mq[0]) begin n_bad++; $display("FAIL simul_order got %h/%h exp %h/%h", if0.rdata, if1.rdata, m_rd0, mq[0]); end
        end
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 8'($urandom), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 8'($urandom), 1'b1, 1'b0);
        step();
        n_cmp++; if (if0.count !== 5'd15 || if0.overflow !== 1'b1) begin n_bad++; $display("FAIL simul_full got cnt %0d ovf %b exp 15 1", if0.count, if0.overflow); end
        n_cmp++; if (if0.rdata !== m_rd0) begin n_bad++; $display("FAIL simul_full_rd got %h exp %h", if0.rdata, m_rd0); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        step();
        drive(1'b1, 8'h3E, 1'b1, 1'b0);
        step();
        n_cmp++; if (if0.count !== 5'd1 || if0.underflow !== 1'b1 || if0.overflow !== 1'b0) begin n_bad++; $display("FAIL simul_empty got cnt %0d udf %b ovf %b exp 1 1 0", if0.count, if0.underflow, if0.overflow); end
        n_cmp++; if (if1.rdata !== 8'h3E) begin n_bad++; $display("FAIL simul_empty_head got %h exp 3e", if1.rdata); end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_fwft();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        step();
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (if1.rempty !== 1'b0 || if1.rdata !== 8'hA5) begin n_bad++; $display("FAIL fwft_show got empty %b rd %h exp 0 a5", if1.rempty, if1.rdata); end
        n_cmp++; if (if0.rdata !== m_rd0) begin n_bad++; $display("FAIL fwft_std_hold got %h exp %h", if0.rdata, m_rd0); end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (if1.rempty !== 1'b1) begin n_bad++; $display("FAIL fwft_pop got empty %b exp 1", if1.rempty); end
        n_cmp++; if (if0.rdata !== 8'hA5) begin n_bad++; $display("FAIL fwft_std_rd got %h exp a5", if0.rdata); end
    endtask

    task automatic test_wraparound();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            step();
        end
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, 8'(k + 3), 1'b1, 1'b0);
            step();
            n_cmp++; if (if0.count !== 5'd3 || if0.wfull !== 1'b0 || if0.rempty !== 1'b0) begin n_bad++; $display("FAIL wrap_flags got cnt %0d full %b empty %b", if0.count, if0.wfull, if0.rempty); end
            n_cmp++; if (if0.rdata !== 8'(k) || if1.rdata !== 8'(k + 1)) begin n_bad++; $display("FAIL wrap_data got %h/%h exp %h/%h", if0.rdata, if1.rdata, 8'(k), 8'(k + 1)); end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_flush_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 8'($urandom), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 8'h77, 1'b0, 1'b1);
        step();
        n_cmp++; if (if0.count !== 5'd0 || if0.rempty !== 1'b1 || if0.overflow !== 1'b0) begin n_bad++; $display("FAIL flush got cnt %0d empty %b ovf %b exp 0 1 0", if0.count, if0.rempty, if0.overflow); end
        drive(1'b1, 8'h3C, 1'b0, 1'b0);
        step();
        n_cmp++; if (if0.count !== 5'd1 || if1.rdata !== 8'h3C) begin n_bad++; $display("FAIL flush_nostore got cnt %0d head %h exp 1 3c", if0.count, if1.rdata); end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        step();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'($urandom), 1'b0, 1'b0);
            step();
        end
        rst = 1'b1;
        drive(1'b1, 8'h99, 1'b1, 1'b0);
        step();
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (if0.count !== 5'd0 || if0.rempty !== 1'b1 || if0.wfull !== 1'b0) begin n_bad++; $display("FAIL rst_mid got cnt %0d empty %b full %b", if0.count, if0.rempty, if0.wfull); end
        n_cmp++; if (if0.ralmost_empty !== 1'b1 || if0.walmost_full !== 1'b0) begin n_bad++; $display("FAIL rst_mid_thr got %b/%b exp 1/0", if0.ralmost_empty, if0.walmost_full); end
        n_cmp++; if (if0.overflow !== 1'b0 || if0.underflow !== 1'b0 || if0.rdata !== 8'h00) begin n_bad++; $display("FAIL rst_mid_err got %b %b %h exp 0 0 00", if0.overflow, if0.underflow, if0.rdata); end
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (if0.rdata !== 8'h5A || if0.rempty !== 1'b1) begin n_bad++; $display("FAIL rst_first got %h empty %b exp 5a 1", if0.rdata, if0.rempty); end
    endtask

    task automatic test_random();
        int ec;
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 50),
                  ($urandom_range(0, 99) < 2));
            step();
            ec = mq.size();
            n_cmp++; if (if0.count !== 5'(ec) || if1.count !== 5'(ec)) begin n_bad++; $display("FAIL rnd_count got %0d/%0d exp %0d", if0.count, if1.count, ec); end
            n_cmp++; if (if0.wfull !== (ec == 16) || if0.rempty !== (ec == 0)) begin n_bad++; $display("FAIL rnd_flags got %b/%b at %0d", if0.wfull, if0.rempty, ec); end
            n_cmp++; if (if0.walmost_full !== (ec >= 14) || if0.ralmost_empty !== (ec <= 2)) begin n_bad++; $display("FAIL rnd_thr got %b/%b at %0d", if0.walmost_full, if0.ralmost_empty, ec); end
            n_cmp++; if (if0.overflow !== m_ov || if0.underflow !== m_un || if1.overflow !== m_ov || if1.underflow !== m_un) begin n_bad++; $display("FAIL rnd_err got %b%b/%b%b exp %b%b", if0.overflow, if0.underflow, if1.overflow, if1.underflow, m_ov, m_un); end
            n_cmp++; if (if0.rdata !== m_rd0) begin n_bad++; $display("FAIL rnd_rdata0 got %h exp %h", if0.rdata, m_rd0); end
            if (ec != 0) begin
                n_cmp++; if (if1.rdata !== mq[0]) begin n_bad++; $display("FAIL rnd_rdata1 got %h exp %h", if1.rdata, mq[0]); end
            end
        end
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_ov  = 0;
        m_un  = 0;
        m_rd0 = 8'h00;
        rst   = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_simultaneous();
        test_fwft();
        test_wraparound();
        test_flush_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
